// File: rtl/sequenciador_pilha.sv
// Stack-machine operation sequencer: pops one or two operands, runs the ALU,
// and pushes the truncated result back, reporting underflow/overflow/truncation.
module sequenciador_pilha #(
    parameter int DATA_W = 16,
    parameter int ALU_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid,
    input  logic [2:0]        op_code,
    input  logic              op_unary,
    output logic              op_ready,
    output logic              stk_pop,
    input  logic [DATA_W-1:0] stk_dout,
    input  logic              stk_empty,
    input  logic              stk_full,
    output logic              stk_push,
    output logic [DATA_W-1:0] stk_din,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_op,
    output logic              alu_start,
    input  logic [ALU_W-1:0]  alu_result,
    input  logic              alu_done,
    output logic              done,
    output logic              err_underflow,
    output logic              err_overflow,
    output logic              res_trunc
);

    typedef enum logic [3:0] {
        IDLE, POP_B, WAIT_B, POP_A, WAIT_A, EXEC, WAIT_ALU, PUSH, FIN, ERR
    } state_t;

    state_t            state, state_nxt;
    logic              unary_r, unary_nxt;
    logic [2:0]        op_nxt;
    logic [DATA_W-1:0] a_nxt, b_nxt, din_nxt;
    logic              uf_nxt, of_nxt, tr_nxt;
    logic              ready_nxt, pop_nxt, push_nxt, start_nxt, done_nxt;

    // Any set bit above the stack word width is lost when the result is pushed.
    function automatic logic trunc_flag(input logic [ALU_W-1:0] r);
        return (r >> DATA_W) != '0;
    endfunction

    always_comb begin
        state_nxt = state;
        unary_nxt = unary_r;
        op_nxt    = alu_op;
        a_nxt     = alu_a;
        b_nxt     = alu_b;
        din_nxt   = stk_din;
        uf_nxt    = err_underflow;
        of_nxt    = err_overflow;
        tr_nxt    = res_trunc;
        unique case (state)
            IDLE: begin
                if (op_valid) begin
                    op_nxt    = op_code;
                    unary_nxt = op_unary;
                    uf_nxt    = 1'b0;
                    of_nxt    = 1'b0;
                    tr_nxt    = 1'b0;
                    state_nxt = POP_B;
                end
            end
            POP_B, POP_A: begin
                // The pop strobe was armed on entry only if the stack had a word.
                if (stk_pop) begin
                    state_nxt = (state == POP_B) ? WAIT_B : WAIT_A;
                end else begin
                    uf_nxt    = 1'b1;
                    state_nxt = ERR;
                end
            end
            WAIT_B: begin
                b_nxt = stk_dout;
                if (unary_r) begin
                    a_nxt     = '0;
                    state_nxt = EXEC;
                end else begin
                    state_nxt = POP_A;
                end
            end
            WAIT_A: begin
                a_nxt     = stk_dout;
                state_nxt = EXEC;
            end
            EXEC: state_nxt = WAIT_ALU;
            WAIT_ALU: begin
                if (alu_done) begin
                    din_nxt   = alu_result[DATA_W-1:0];
                    tr_nxt    = trunc_flag(alu_result);
                    state_nxt = PUSH;
                end
            end
            PUSH: begin
                if (stk_push) begin
                    state_nxt = FIN;
                end else begin
                    of_nxt    = 1'b1;
                    state_nxt = ERR;
                end
            end
            FIN, ERR: state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase

        // Strobes are decided one cycle ahead so they appear registered in their state.
        ready_nxt = (state_nxt == IDLE);
        pop_nxt   = ((state_nxt == POP_B) || (state_nxt == POP_A)) && !stk_empty;
        push_nxt  = (state_nxt == PUSH) && !stk_full;
        start_nxt = (state_nxt == EXEC);
        done_nxt  = (state_nxt == FIN) || (state_nxt == ERR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            unary_r       <= 1'b0;
            op_ready      <= 1'b1;
            stk_pop       <= 1'b0;
            stk_push      <= 1'b0;
            alu_start     <= 1'b0;
            done          <= 1'b0;
            alu_op        <= '0;
            alu_a         <= '0;
            alu_b         <= '0;
            stk_din       <= '0;
            err_underflow <= 1'b0;
            err_overflow  <= 1'b0;
            res_trunc     <= 1'b0;
        end else begin
            state         <= state_nxt;
            unary_r       <= unary_nxt;
            op_ready      <= ready_nxt;
            stk_pop       <= pop_nxt;
            stk_push      <= push_nxt;
            alu_start     <= start_nxt;
            done          <= done_nxt;
            alu_op        <= op_nxt;
            alu_a         <= a_nxt;
            alu_b         <= b_nxt;
            stk_din       <= din_nxt;
            err_underflow <= uf_nxt;
            err_overflow  <= of_nxt;
            res_trunc     <= tr_nxt;
        end
    end

endmodule

// File: doc/sequenciador_pilha.md
SEQUENCIADOR_PILHA -- requirements
Module: sequenciador_pilha

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning the stack word width.
REQ-002 The block SHALL have parameter ALU_W, default 32, meaning the ALU result width (ALU_W >= DATA_W).
REQ-003 The block SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have port op_valid  input  1  control unit requests an operation.
REQ-006 The block SHALL have port op_code  input  3  ALU operation, passed unchanged to alu_op.
REQ-007 The block SHALL have port op_unary  input  1  1 = one operand, 0 = two operands.
REQ-008 The block SHALL have port op_ready  output  1  request accepted when op_valid & op_ready.
REQ-009 The block SHALL have port stk_pop  output  1  one-cycle pop strobe to the stack.
REQ-010 The block SHALL have port stk_dout  input  DATA_W  popped word, valid the cycle after stk_pop.
REQ-011 The block SHALL have port stk_empty  input  1  stack holds no words.
REQ-012 The block SHALL have port stk_full  input  1  stack holds 16 words.
REQ-013 The block SHALL have port stk_push  output  1  one-cycle push strobe to the stack.
REQ-014 The block SHALL have port stk_din  output  DATA_W  word to push.
REQ-015 The block SHALL have port alu_a, alu_b  output  DATA_W  operands: a = second popped, b = first popped (top).
REQ-016 The block SHALL have port alu_op  output  3  latched op_code.
REQ-017 The block SHALL have port alu_start  output  1  one-cycle ALU start strobe.
REQ-018 The block SHALL have port alu_result  input  ALU_W  ALU result, valid with alu_done.
REQ-019 The block SHALL have port alu_done  input  1  ALU result ready.
REQ-020 The block SHALL have port done  output  1  one-cycle completion pulse.
REQ-021 The block SHALL have port err_underflow, err_overflow, res_trunc  output  1 each  status, valid with done.

Function
REQ-022 The block SHALL implement FSM states IDLE, POP_B, WAIT_B, POP_A, WAIT_A, EXEC, WAIT_ALU, PUSH, FIN, ERR; all outputs registered.
REQ-023 The block SHALL assert op_ready only in IDLE; on acceptance it SHALL latch op_code/op_unary, clear status bits, and go to POP_B.
REQ-024 In POP_B/POP_A the block SHALL assert stk_pop one cycle if stk_empty=0, else go to ERR with err_underflow=1 and no pop.
REQ-025 In WAIT_B the block SHALL capture stk_dout into alu_b, then go to EXEC if op_unary=1 (alu_a=0), else POP_A.
REQ-026 In WAIT_A the block SHALL capture stk_dout into alu_a, then go to EXEC.
REQ-027 EXEC SHALL pulse alu_start one cycle, then go to WAIT_ALU; alu_a/alu_b/alu_op SHALL hold until the next accepted op.
REQ-028 WAIT_ALU SHALL wait indefinitely for alu_done; on alu_done it SHALL latch alu_result[DATA_W-1:0] into stk_din and set res_trunc = |alu_result[ALU_W-1:DATA_W].
REQ-029 PUSH SHALL assert stk_push one cycle if stk_full=0 then go to FIN, else go to ERR with err_overflow=1 and no push.
REQ-030 FIN and ERR SHALL each pulse done one cycle and return to IDLE; status bits SHALL hold until the next acceptance.
REQ-031 Binary-op latency SHALL be: accept at T, pops at T+1 and T+3, alu_start at T+5, push at T+6+k (k = cycles waiting for alu_done, k>=1 counts alu_done at T+6 as k=1 -> push T+7), done at T+8 for k=1, op_ready again at T+9.
REQ-032 The block SHALL never assert stk_pop and stk_push in the same cycle; op_valid outside IDLE SHALL be ignored.
REQ-033 An underflow on POP_A SHALL leave the first popped word consumed (no restore).

Reset
REQ-034 rst=1 SHALL immediately force IDLE, op_ready=1, and all strobes, done, status bits, alu_a, alu_b, alu_op, stk_din to 0.
REQ-035 Reset asserted mid-operation SHALL abort it with no further pop or push after release.

Verification
REQ-036 Binary: stack 7 then 2 on top, op_code=SUB -> pops T+1,T+3, alu_a=7, alu_b=2, alu_result=5 -> stk_din=5 pushed, done, status 0.
REQ-037 Unary: top=0x00FF, op_unary=1 -> single pop, alu_a=0, alu_b=0x00FF, push, done at T+6 for k=1.
REQ-038 Underflow: stk_empty=1 at POP_B -> no stk_pop, done with err_underflow=1; one-word stack binary op -> one pop, err_underflow=1.
REQ-039 Truncation: alu_result=0x0001_2345 -> stk_din=0x2345, res_trunc=1; full stack at PUSH -> no push, err_overflow=1.
REQ-040 Reset in WAIT_ALU with alu_done held high -> no stk_push ever; op_ready=1 immediately after rst rises.
